// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared processor constants and fetch types
// Purpose: constants shared by the fetch stage and its neighbours.
//   INST_W           instruction word width
//   RESET_PC_DEFAULT default first fetch address after reset
//   NOP_INST         instruction presented to decode while nothing is valid
//   fetch_entry_t    one instruction buffer entry {pc, inst}
package fetch_unit_pkg;

   localparam int                INST_W           = 32;
   localparam logic [31:0]       RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush
// Purpose: DEPTH-entry FIFO used as the instruction buffer and the PC queue.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             empties the FIFO (wins over push/pop)
//   push, push_data   write one entry (ignored when full)
//   pop               remove the head entry (ignored when empty)
//   head              current head entry (RESET_VAL straight out of reset)
//   full, empty       occupancy flags
//   count             number of valid entries
module fetch_fifo #(
   parameter int              WIDTH     = 64,
   parameter int              DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_next(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch with redirect
// Purpose: issues in-order word fetches, buffers returned instructions for
// decode, and squashes wrong-path responses after a redirect.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/addr/ready        fetch request handshake
//   imem_rsp_valid/data              in-order instruction responses
//   redirect_valid/pc                taken branch/jump from execute
//   inst_valid/data/pc, inst_ready   instruction handoff to decode
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   output logic [31:0]       imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst_data,
   output logic [31:0]       inst_pc,
   input  logic              inst_ready
);

   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]   pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW:0]   credit_used;

   fetch_entry_t  buf_head;
   fetch_entry_t  buf_in;
   logic          buf_full, buf_empty, buf_push, buf_pop;
   logic [CW-1:0] buf_count;
   logic [31:0]   pcq_head;
   logic          pcq_full, pcq_empty;
   logic [CW-1:0] pcq_count;

   logic accept;
   logic rsp_live;
   logic rsp_take;

   // Credit counts both words in flight and words already buffered, so every
   // response always has a buffer slot waiting for it.
   assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
   assign imem_req_valid = (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a leftover from before reset.
   assign rsp_live = imem_rsp_valid && (outstanding != '0);
   assign rsp_take = rsp_live && (discard == '0);

   assign buf_in.pc   = pcq_head;
   assign buf_in.inst = imem_rsp_data;
   assign buf_push    = rsp_take && !redirect_valid;
   assign buf_pop     = inst_valid && inst_ready;

   assign inst_valid = !buf_empty;
   assign inst_data  = buf_head.inst;
   assign inst_pc    = buf_head.pc;

   fetch_fifo #(
      .WIDTH     ($bits(fetch_entry_t)),
      .DEPTH     (DEPTH),
      .RESET_VAL ({RESET_PC, NOP_INST})
   ) u_inst_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (buf_push),
      .push_data (buf_in),
      .pop       (buf_pop),
      .head      (buf_head),
      .full      (buf_full),
      .empty     (buf_empty),
      .count     (buf_count)
   );

   fetch_fifo #(
      .WIDTH     (32),
      .DEPTH     (DEPTH),
      .RESET_VAL (RESET_PC)
   ) u_pc_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (accept),
      .push_data (pc),
      .pop       (rsp_take),
      .head      (pcq_head),
      .full      (pcq_full),
      .empty     (pcq_empty),
      .count     (pcq_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CW'(accept) - CW'(rsp_live);
         if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
            // Everything still in flight after this cycle is wrong-path.
            discard <= outstanding - CW'(rsp_live);
         end else begin
            if (accept) pc <= pc + 32'd4;
            if (rsp_live && (discard != '0)) discard <= discard - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(buf_push && buf_full))
            else $error("fetch_unit: instruction buffer push while full");
         assert (!(accept && pcq_full))
            else $error("fetch_unit: pc queue push while full");
         assert (!(rsp_take && pcq_empty))
            else $error("fetch_unit: response without a queued pc");
         assert (CW'(pcq_count + discard) == outstanding)
            else $error("fetch_unit: pc queue out of step with outstanding");
         assert (!(imem_rsp_valid && (outstanding == '0)))
            else $warning("fetch_unit: stray imem response ignored");
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam int          DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;

   fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          accepts = 0;
   int          deliveries = 0;
   logic [31:0] model_pc = RPC;
   logic [31:0] last_acc_addr = '0;
   logic [31:0] mon_pc;

   int          budget = -1;
   int          lat_min = 1;
   int          lat_max = 1;
   int          redir_pct = 0;
   int          ir_mode = 1;
   bit          rdy_rand = 0;
   bit          rsp_rand = 0;
   bit          keep_pending = 0;
   bit          redir_once = 0;
   logic [31:0] redir_target = '0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ {a[9:2], 24'h0};
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, expv);
      end
   endtask

   // Memory, redirect source and reference fetch model.
   always begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = 1'b0;
         redirect_valid = 1'b0;
         inst_ready     = 1'b0;
      end else begin
         imem_rsp_valid = 1'b0;
         if (pend.size() > 0 && pend[0].due <= cyc && (!rsp_rand || $urandom_range(0, 3) != 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_fn(pend[0].addr);
         end
         if (budget == 0) imem_req_ready = 1'b0;
         else if (rdy_rand) imem_req_ready = 1'($urandom_range(0, 1));
         else imem_req_ready = 1'b1;
         case (ir_mode)
            0:       inst_ready = 1'b0;
            1:       inst_ready = 1'b1;
            default: inst_ready = 1'($urandom_range(0, 1));
         endcase
         redirect_valid = 1'b0;
         if (redir_once) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            redir_once     = 0;
         end else if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
         end
      end
      #1;
      if (!rst_n) begin
         model_pc = RPC;
         if (!keep_pending) pend.delete();
      end else begin
         if (imem_rsp_valid) void'(pend.pop_front());
         if (redirect_valid) begin
            check32("no_req_on_redirect", {31'b0, imem_req_valid}, 32'h0);
            model_pc = {redirect_pc[31:2], 2'b00};
         end else if (imem_req_valid && imem_req_ready) begin
            check32("req_addr", imem_req_addr, model_pc);
            exp_q.push_back(model_pc);
            pend.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            last_acc_addr = imem_req_addr;
            model_pc = model_pc + 32'd4;
            accepts++;
            if (budget > 0) budget--;
         end
      end
   end

   // Monitor: every delivered instruction must be the oldest expected one.
   always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_inst actual_pc=%h required=none", inst_pc);
            end else begin
               mon_pc = exp_q.pop_front();
               check32("inst_pc", inst_pc, mon_pc);
               check32("inst_data", inst_data, mem_fn(mon_pc));
            end
         end
         if (redirect_valid) exp_q.delete();
      end
   end

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      #3;
      check32("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      check32("rst_inst_data", inst_data, NOP_INST);
      check32("rst_inst_pc", inst_pc, RPC);
      check32("rst_req_addr", imem_req_addr, RPC);
      @(posedge clk);
      #1 rst_n = 1'b1;
      accepts = 0;
   endtask

   task automatic wait_inst(input string name, input logic [31:0] pc_exp);
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         #3;
         if (inst_valid) begin
            seen = 1;
            check32(name, inst_pc, pc_exp);
         end
      end
      if (!seen) check32({name, "_timeout"}, 32'h0, 32'h1);
   endtask

   initial begin
      // Startup, first fetch latency and streaming.
      pulse_reset();
      @(negedge clk); #3;
      check32("req_valid_after_reset", {31'b0, imem_req_valid}, 32'h1);
      check32("req_addr_after_reset", imem_req_addr, RPC);
      @(negedge clk); #3;
      check32("inst_valid_c1", {31'b0, inst_valid}, 32'h0);
      @(negedge clk); #3;
      check32("inst_valid_c2", {31'b0, inst_valid}, 32'h1);
      check32("inst_pc_c2", inst_pc, RPC);
      check32("inst_data_c2", inst_data, mem_fn(RPC));
      deliveries = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #3;
         if (inst_valid && inst_ready) deliveries++;
      end
      check32("stream_progress", {31'b0, deliveries >= 15}, 32'h1);

      // Decode stalled: credit limits requests to DEPTH.
      ir_mode = 0;
      pulse_reset();
      repeat (10) @(negedge clk);
      #3;
      check32("stall_accepts", accepts, DEPTH);
      check32("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check32("stall_head_pc", inst_pc, RPC);
      ir_mode = 1;
      repeat (10) @(negedge clk);
      #3;

      // Redirect with two requests outstanding.
      lat_min = 4; lat_max = 4;
      pulse_reset();
      @(negedge clk);
      @(negedge clk); #3;
      check32("two_outstanding", accepts, 2);
      redir_target = 32'h100;
      redir_once   = 1;
      @(negedge clk); #3;
      @(negedge clk); #3;
      check32("redirect_addr_100", imem_req_addr, 32'h100);
      wait_inst("first_after_redirect", 32'h100);

      // Misaligned redirect target.
      lat_min = 1; lat_max = 1;
      redir_target = 32'h103;
      redir_once   = 1;
      @(negedge clk);
      @(negedge clk); #3;
      check32("redirect_align", imem_req_addr, 32'h100);

      // Address wrap at the top of memory.
      redir_target = 32'hFFFF_FFF8;
      redir_once   = 1;
      @(negedge clk); #3;
      accepts = 0;
      for (int i = 0; i < 30 && accepts < 3; i++) begin
         @(negedge clk); #3;
      end
      check32("wrap_accepts", accepts, 3);
      check32("wrap_addr", last_acc_addr, 32'h0);

      // Reset with one request in flight; its late response must be ignored.
      lat_min = 6; lat_max = 6;
      budget  = 1;
      pulse_reset();
      repeat (3) @(negedge clk);
      #3;
      check32("one_outstanding", accepts, 1);
      budget       = 0;
      keep_pending = 1;
      pulse_reset();
      for (int i = 0; i < 20 && pend.size() > 0; i++) begin
         @(negedge clk); #3;
      end
      check32("late_rsp_sent", pend.size(), 0);
      repeat (2) begin
         @(negedge clk); #3;
         check32("late_rsp_ignored", {31'b0, inst_valid}, 32'h0);
      end
      keep_pending = 0;
      lat_min = 1; lat_max = 1;
      accepts = 0;
      budget  = -1;
      for (int i = 0; i < 10 && accepts < 1; i++) begin
         @(negedge clk); #3;
      end
      check32("refetch_addr", last_acc_addr, RPC);
      wait_inst("refetch_inst", RPC);

      // Randomised traffic with redirects.
      rdy_rand = 1; rsp_rand = 1; lat_min = 1; lat_max = 3;
      ir_mode = 2; redir_pct = 4;
      pulse_reset();
      repeat (1500) @(negedge clk);
      #3;
      redir_pct = 0; rdy_rand = 0; rsp_rand = 0; ir_mode = 1; budget = 0;
      for (int i = 0; i < 300 && (pend.size() > 0 || exp_q.size() > 0); i++) begin
         @(negedge clk); #3;
      end
      check32("drain_expected", exp_q.size(), 0);
      check32("drain_pending", pend.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
